// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between port A (CPU) and port B (loader) with round-robin arbitration.
// Define RAM_ARB_FIXED_PRIO_EN to make port A win every tie instead of alternating.
module ram_arbiter #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [addr_width-1:0] addr_a,
  input  logic [data_width-1:0] wdata_a,
  output logic                  ack_a,
  output logic [data_width-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [addr_width-1:0] addr_b,
  input  logic [data_width-1:0] wdata_b,
  output logic                  ack_b,
  output logic [data_width-1:0] rdata_b,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

  state_t                state, state_next;
  port_t                 owner, owner_next;
  logic                  load;
  logic                  idle_pick_b;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  we_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign idle_pick_b = !req_a;
`else
  port_t last;
  // On a tie, the port that was not served most recently wins.
  assign idle_pick_b = !req_a || (last == PORT_A);
`endif

  always_comb begin
    state_next = state;
    owner_next = owner;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (req_a || req_b) begin
          load       = 1'b1;
          owner_next = idle_pick_b ? PORT_B : PORT_A;
          state_next = ACCESS;
        end
      end
      ACCESS: state_next = ACK;
      ACK: begin
        // The owner still holds req while it samples ack, so only the other port can chain in.
        if (owner == PORT_A && req_b) begin
          load       = 1'b1;
          owner_next = PORT_B;
          state_next = ACCESS;
        end else if (owner == PORT_B && req_a) begin
          load       = 1'b1;
          owner_next = PORT_A;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= PORT_A;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last    <= PORT_B;
`endif
    end else begin
      state <= state_next;
      owner <= owner_next;
`ifndef RAM_ARB_FIXED_PRIO_EN
      if (state == ACK) last <= owner;
`endif
      if (load) begin
        addr_q  <= (owner_next == PORT_B) ? addr_b  : addr_a;
        wdata_q <= (owner_next == PORT_B) ? wdata_b : wdata_a;
        we_q    <= (owner_next == PORT_B) ? we_b    : we_a;
      end
    end
  end

  // A write is gated by rst so a reset landing in ACCESS never corrupts the RAM.
  assign ram_addr = addr_q;
  assign ram_din  = wdata_q;
  assign ram_we   = (state == ACCESS) && we_q && !rst;
  assign ack_a    = (state == ACK) && (owner == PORT_A);
  assign ack_b    = (state == ACK) && (owner == PORT_B);
  assign rdata_a  = ack_a ? ram_dout : '0;
  assign rdata_b  = ack_b ? ram_dout : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized contention against a shadow-memory model.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          local_clk = 1'b0;
  logic          rst;
  logic          req_a, we_a, req_b, we_b;
  logic [AW-1:0] addr_a, addr_b, ram_addr;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b, ram_din, ram_dout;
  logic          ack_a, ack_b, ram_we, busy;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram_mem   [2**AW];
  logic [DW-1:0] mem_model [2**AW];

  int compared   = 0;
  int mismatched = 0;

  always #5 local_clk = ~local_clk;

  ram_arbiter #(.addr_width(AW), .data_width(DW)) dut (
    .clk(local_clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout), .busy(busy)
  );

  // Single-port synchronous RAM with registered dout; the preload port lets the bench seed contents.
  always @(posedge local_clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge local_clk);
    pre_we = 1'b0;
    mem_model[a] = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(negedge local_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    @(negedge local_clk);
    @(negedge local_clk);
    compared++; if (busy !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_busy: got %0h, expected 0", busy); end
    compared++; if (ack_a !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_ack_a: got %0h, expected 0", ack_a); end
    compared++; if (ack_b !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_ack_b: got %0h, expected 0", ack_b); end
    compared++; if (ram_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ram_we: got %0h, expected 0", ram_we); end
    compared++; if (ram_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_ram_addr: got %0h, expected 0", ram_addr); end
    compared++; if (ram_din !== '0)  begin mismatched++; $display("[TB] FAIL reset_ram_din: got %0h, expected 0", ram_din); end
    compared++; if (rdata_a !== '0)  begin mismatched++; $display("[TB] FAIL reset_rdata_a: got %0h, expected 0", rdata_a); end
    compared++; if (rdata_b !== '0)  begin mismatched++; $display("[TB] FAIL reset_rdata_b: got %0h, expected 0", rdata_b); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    preload(8'h10, 8'h5A);
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h10; wdata_a = 8'h00;
    @(negedge local_clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL read_busy_c1: got %0h, expected 1", busy); end
    compared++; if (ack_a !== 1'b0) begin mismatched++; $display("[TB] FAIL read_ack_a_c1: got %0h, expected 0", ack_a); end
    @(negedge local_clk);
    compared++; if (ack_a !== 1'b1) begin mismatched++; $display("[TB] FAIL read_ack_a_c2: got %0h, expected 1", ack_a); end
    compared++; if (rdata_a !== 8'h5A) begin mismatched++; $display("[TB] FAIL read_rdata_a: got %0h, expected 5a", rdata_a); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL read_busy_c2: got %0h, expected 1", busy); end
    compared++; if (ack_b !== 1'b0) begin mismatched++; $display("[TB] FAIL read_ack_b: got %0h, expected 0", ack_b); end
    req_a = 1'b0;
    @(negedge local_clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL read_busy_c3: got %0h, expected 0", busy); end
    compared++; if (ack_a !== 1'b0) begin mismatched++; $display("[TB] FAIL read_ack_a_c3: got %0h, expected 0", ack_a); end
  endtask

  task automatic test_write_read_b();
    logic exp_we [1:5];
    logic exp_ack [1:5];
    exp_we  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_ack = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_b = 1'b1; we_b = 1'b1; addr_b = 8'h33; wdata_b = 8'hC3;
    for (int c = 1; c <= 5; c++) begin
      @(negedge local_clk);
      compared++; if (ram_we !== exp_we[c]) begin mismatched++; $display("[TB] FAIL wrb_ram_we_c%0d: got %0h, expected %0h", c, ram_we, exp_we[c]); end
      compared++; if (ack_b !== exp_ack[c]) begin mismatched++; $display("[TB] FAIL wrb_ack_b_c%0d: got %0h, expected %0h", c, ack_b, exp_ack[c]); end
      if (c == 1) begin
        compared++; if (ram_addr !== 8'h33) begin mismatched++; $display("[TB] FAIL wrb_ram_addr: got %0h, expected 33", ram_addr); end
        compared++; if (ram_din !== 8'hC3) begin mismatched++; $display("[TB] FAIL wrb_ram_din: got %0h, expected c3", ram_din); end
      end
      if (c == 2) begin
        we_b = 1'b0;
        mem_model[8'h33] = 8'hC3;
      end
      if (c == 5) begin
        compared++; if (rdata_b !== mem_model[8'h33]) begin mismatched++; $display("[TB] FAIL wrb_rdata_b: got %0h, expected %0h", rdata_b, mem_model[8'h33]); end
        req_b = 1'b0;
      end
    end
    @(negedge local_clk);
  endtask

  task automatic test_simultaneous();
    reset_dut();
    preload(8'h01, 8'h11);
    preload(8'h02, 8'h22);
    req_a = 1'b1; we_a = 1'b0; addr_a = 8'h01;
    req_b = 1'b1; we_b = 1'b0; addr_b = 8'h02;
    @(negedge local_clk);
    @(negedge local_clk);
    compared++; if (ack_a !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_ack_a_c2: got %0h, expected 1", ack_a); end
    compared++; if (rdata_a !== 8'h11) begin mismatched++; $display("[TB] FAIL sim_rdata_a: got %0h, expected 11", rdata_a); end
    compared++; if (ack_b !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_ack_b_c2: got %0h, expected 0", ack_b); end
    req_a = 1'b0;
    @(negedge local_clk);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_busy_c3: got %0h, expected 1", busy); end
    @(negedge local_clk);
    compared++; if (ack_b !== 1'b1) begin mismatched++; $display("[TB] FAIL sim_ack_b_c4: got %0h, expected 1", ack_b); end
    compared++; if (rdata_b !== 8'h22) begin mismatched++; $display("[TB] FAIL sim_rdata_b: got %0h, expected 22", rdata_b); end
    req_b = 1'b0;
    @(negedge local_clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL sim_busy_c5: got %0h, expected 0", busy); end
  endtask

  task automatic test_contention();
    int  done = 0, cnt_a = 0, cnt_b = 0, cyc = 0, last_cyc = 0;
    logic last_served_b = 1'b1;
    logic port_b, exp_b;
    reset_dut();
    for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom_range(0, 255)));
    we_a = 1'($urandom); addr_a = AW'($urandom_range(0, 15)); wdata_a = DW'($urandom);
    we_b = 1'($urandom); addr_b = AW'($urandom_range(0, 15)); wdata_b = DW'($urandom);
    req_a = 1'b1; req_b = 1'b1;
    while (done < 20 && cyc < 200) begin
      @(negedge local_clk);
      cyc++;
      if (ack_a && ack_b) begin
        compared++; mismatched++; $display("[TB] FAIL cont_both_acks: got 11, expected one-hot at cycle %0d", cyc);
      end else if (ack_a || ack_b) begin
        port_b = ack_b;
        // Both ports are always pending, so the model grants whoever was not served last.
        exp_b = !last_served_b;
        compared++; if (port_b !== exp_b) begin mismatched++; $display("[TB] FAIL cont_grant_%0d: got port %0h, expected port %0h", done, port_b, exp_b); end
        compared++; if ((cyc - last_cyc) != 2) begin mismatched++; $display("[TB] FAIL cont_spacing_%0d: got %0d cycles, expected 2", done, cyc - last_cyc); end
        if (!port_b) begin
          if (!we_a) begin
            compared++; if (rdata_a !== mem_model[addr_a]) begin mismatched++; $display("[TB] FAIL cont_rdata_a_%0d: got %0h, expected %0h", done, rdata_a, mem_model[addr_a]); end
          end else mem_model[addr_a] = wdata_a;
          cnt_a++;
          we_a = 1'($urandom); addr_a = AW'($urandom_range(0, 15)); wdata_a = DW'($urandom);
          if (cnt_a == 10) req_a = 1'b0;
        end else begin
          if (!we_b) begin
            compared++; if (rdata_b !== mem_model[addr_b]) begin mismatched++; $display("[TB] FAIL cont_rdata_b_%0d: got %0h, expected %0h", done, rdata_b, mem_model[addr_b]); end
          end else mem_model[addr_b] = wdata_b;
          cnt_b++;
          we_b = 1'($urandom); addr_b = AW'($urandom_range(0, 15)); wdata_b = DW'($urandom);
          if (cnt_b == 10) req_b = 1'b0;
        end
        last_served_b = port_b;
        last_cyc = cyc;
        done++;
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    compared++; if (done != 20) begin mismatched++; $display("[TB] FAIL cont_total: got %0d, expected 20", done); end
    compared++; if (cnt_a != 10) begin mismatched++; $display("[TB] FAIL cont_count_a: got %0d, expected 10", cnt_a); end
    compared++; if (cnt_b != 10) begin mismatched++; $display("[TB] FAIL cont_count_b: got %0d, expected 10", cnt_b); end
    repeat (2) @(negedge local_clk);
  endtask

  task automatic test_reset_in_access();
    reset_dut();
    preload(8'h40, 8'h77);
    req_a = 1'b1; we_a = 1'b1; addr_a = 8'h40; wdata_a = 8'hFF;
    @(negedge local_clk);
    compared++; if (ram_we !== 1'b1) begin mismatched++; $display("[TB] FAIL rsta_we_before: got %0h, expected 1", ram_we); end
    rst = 1'b1; req_a = 1'b0;
    #1;
    compared++; if (ram_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rsta_we_forced: got %0h, expected 0", ram_we); end
    @(negedge local_clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rsta_busy: got %0h, expected 0", busy); end
    compared++; if (ack_a !== 1'b0) begin mismatched++; $display("[TB] FAIL rsta_ack_a: got %0h, expected 0", ack_a); end
    compared++; if (ram_addr !== '0) begin mismatched++; $display("[TB] FAIL rsta_ram_addr: got %0h, expected 0", ram_addr); end
    compared++; if (ram_din !== '0) begin mismatched++; $display("[TB] FAIL rsta_ram_din: got %0h, expected 0", ram_din); end
    compared++; if (rdata_a !== '0) begin mismatched++; $display("[TB] FAIL rsta_rdata_a: got %0h, expected 0", rdata_a); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge local_clk);
      compared++; if ((ack_a | ack_b) !== 1'b0) begin mismatched++; $display("[TB] FAIL rsta_no_ack_%0d: got %0h, expected 0", c, ack_a | ack_b); end
    end
    compared++; if (ram_mem[8'h40] !== mem_model[8'h40]) begin mismatched++; $display("[TB] FAIL rsta_ram_content: got %0h, expected %0h", ram_mem[8'h40], mem_model[8'h40]); end
  endtask

  task automatic test_idle();
    req_a = 1'b0; req_b = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge local_clk);
      compared++; if (ram_we !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_ram_we_%0d: got %0h, expected 0", c, ram_we); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy_%0d: got %0h, expected 0", c, busy); end
      compared++; if ((ack_a | ack_b) !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_ack_%0d: got %0h, expected 0", c, ack_a | ack_b); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 2**AW; i++) mem_model[i] = '0;
    @(negedge local_clk);
    $display("[TB] starting ram_arbiter bench");
    test_reset();
    test_single_read();
    test_write_read_b();
    test_simultaneous();
    test_contention();
    test_reset_in_access();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous RAM (addr/din/we in, registered dout, one access per active clock edge) between two requesters.
- Port A is the CPU data side; port B is the loader/debug side.
- Performs round-robin arbitration, latches the winner's command, drives the RAM and returns a one-cycle ack with read data.
- Sits between the processor core, the loader and the RAM instance in the top level.

Parameters:
- addr_width, 8, RAM address width in bits. Must match the RAM instance.
- data_width, 8, RAM data width in bits. Must match the RAM instance.

Ports:
- clk  in  1  System clock. All logic updates on posedge.
- rst  in  1  Synchronous reset, active-high.
- req_a  in  1  Port A request. Held high, with we_a/addr_a/wdata_a stable, until ack_a is seen.
- we_a  in  1  Port A: 1 = write, 0 = read.
- addr_a  in  addr_width  Port A address.
- wdata_a  in  data_width  Port A write data.
- ack_a  out  1  Port A access complete. Single-cycle pulse.
- rdata_a  out  data_width  Port A read data. Valid while ack_a is high.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as port A, for port B.
- ram_addr  out  addr_width  To RAM addr.
- ram_din  out  data_width  To RAM din.
- ram_we  out  1  To RAM we.
- ram_dout  in  data_width  From RAM dout.
- busy  out  1  High when state is not IDLE.

Behaviour:
- States:
  - IDLE: no transaction in progress.
  - ACCESS: latched command is presented to the RAM.
  - ACK: result returned to the owner.
- Registers: state, owner (A/B), last (port most recently served), addr_q, wdata_q, we_q.
- Reset values:
  - state = IDLE, owner = A, last = B (so A wins the first tie), addr_q = 0, wdata_q = 0, we_q = 0.
  - All outputs are 0. ram_we is forced to 0 in any cycle where rst = 1.
- IDLE:
  - Neither request: stay in IDLE.
  - One request: that port wins.
  - Both requests: the port that is not `last` wins.
  - On a win, at the next edge: latch the winner's addr/wdata/we into the _q registers, set owner, go to ACCESS.
- ACCESS:
  - ram_addr = addr_q, ram_din = wdata_q, ram_we = we_q.
  - The RAM performs the access at the edge that ends ACCESS.
  - Next state: ACK.
- ACK:
  - ack_<owner> = 1; rdata_<owner> = ram_dout.
  - The non-owner's ack is 0. rdata of the non-owner port is don't-care.
  - On write acks, rdata is don't-care.
  - ram_we = 0.
  - last is set to owner at the edge that ends ACK.
  - Owner's req is ignored during ACK, because the requester drops it only after sampling ack.
  - If the non-owner's req is high: latch its command, owner = non-owner, go directly to ACCESS.
  - Otherwise go to IDLE.
- Outside ACCESS: ram_addr = addr_q, ram_din = wdata_q, ram_we = 0.
- Latency: request sampled at edge N, ack high during cycle N+2.
- Throughput:
  - Uncontended: one access per 3 cycles.
  - Alternating A/B: one access per 2 cycles.
- Fairness: under continuous requests from both ports, grants strictly alternate and neither port starves.
- Requests that change while not granted are only sampled when arbitration occurs.
- A req drop before ack is a protocol violation; the command already latched still completes.
- Reset mid-transaction: next state is IDLE, no ack is issued, the access is lost. A write in ACCESS with rst = 1 is suppressed.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN
- Defined:
  - Fixed priority, port A always wins ties in IDLE and in ACK.
  - In ACK, a pending B request still proceeds only if A's req is low or A is the current owner.
  - last is unused.
- Undefined: round-robin as above.

Test Plan:
- Single read:
  - Preload RAM[0x10] = 0x5A.
  - Pulse req_a (we_a = 0, addr_a = 0x10) from edge 0.
  - Required: ack_a high in cycle 2 with rdata_a = 0x5A; busy high in cycles 1-2; ack_b never high.
- Write then read, port B:
  - req_b write addr 0x33 data 0xC3; on ack, read 0x33.
  - Required: ram_we high only during the ACCESS cycle of the write; the read ack returns 0xC3.
- Simultaneous requests after reset:
  - req_a and req_b high together, reads of 0x01/0x02 holding 0x11/0x22.
  - Required: ack_a with 0x11 in cycle 2, then ack_b with 0x22 in cycle 4 via ACK→ACCESS with no IDLE.
- Sustained contention:
  - Both ports re-request immediately after every ack for 20 transactions.
  - Required: grants alternate A, B, A, B...; each port gets 10.
  - With RAM_ARB_FIXED_PRIO_EN, B is granted only when A's req is low.
- Reset in ACCESS:
  - Start a write of 0xFF to 0x40, assert rst during the ACCESS cycle.
  - Required: RAM[0x40] unchanged, no ack, all outputs 0 after the edge, state IDLE.
- Idle quiescence:
  - No requests for 10 cycles.
  - Required: ram_we = 0, busy = 0, acks 0 throughout.
